// File: rtl/nic3_pwr_seq_if.sv
// nic3_pwr_seq_if
// Slot power-sequencer signal bundle between the board power-control logic,
// the NIC3 slot rails and the sequencer.
//   master : board/slot side; drives the request, fault clear and power-goods,
//            observes the rail enables and status
//   slave  : sequencer side
// Signals:
//   pwr_req    1 = slot power requested
//   fault_clr  one-cycle pulse, clears a latched fault
//   pg_aux/pg_m12/pg_m33  rail power-good inputs
//   en_aux/en_m12/en_m33  rail enables
//   pwr_ok     slot fully powered
//   fault      latched fault flag
//   fault_code 0 none, 1 AUX t/o, 2 M12 t/o, 3 M33 t/o, 4 PG lost in ON
//   seq_state  sequencer state, debug only
interface nic3_pwr_seq_if;
   logic       pwr_req;
   logic       fault_clr;
   logic       pg_aux;
   logic       pg_m12;
   logic       pg_m33;
   logic       en_aux;
   logic       en_m12;
   logic       en_m33;
   logic       pwr_ok;
   logic       fault;
   logic [2:0] fault_code;
   logic [3:0] seq_state;

   modport master (
      output pwr_req, fault_clr, pg_aux, pg_m12, pg_m33,
      input  en_aux, en_m12, en_m33, pwr_ok, fault, fault_code, seq_state
   );

   modport slave (
      input  pwr_req, fault_clr, pg_aux, pg_m12, pg_m33,
      output en_aux, en_m12, en_m33, pwr_ok, fault, fault_code, seq_state
   );
endinterface

// File: rtl/nic3_pwr_seq.sv
// nic3_pwr_seq
// OCP NIC3 slot power sequencer. Brings up AUX, MAIN 12V, MAIN 3V3 in order,
// each step gated on its power-good with a timeout, separated by fixed
// delays; powers down in reverse order; latches a fault code on a
// power-good timeout or on power-good loss while fully powered.
// Ports:
//   clk_in  system clock
//   iRst    asynchronous active-high reset
//   bus     nic3_pwr_seq_if.slave (request/power-good in, enables/status out)
// Parameters:
//   STEP_DLY    cycles held in each delay state (state lasts STEP_DLY+1)
//   PG_TIMEOUT  cycles allowed for a rail power-good before fault
module nic3_pwr_seq #(
   parameter logic [15:0] STEP_DLY   = 16'd1000,
   parameter logic [15:0] PG_TIMEOUT = 16'd5000
) (
   input  logic           clk_in,
   input  logic           iRst,
   nic3_pwr_seq_if.slave  bus
);

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      W_AUX   = 4'd1,
      D_AUX   = 4'd2,
      W_M12   = 4'd3,
      D_M12   = 4'd4,
      W_M33   = 4'd5,
      ON      = 4'd6,
      OFF_M33 = 4'd7,
      OFF_M12 = 4'd8,
      OFF_AUX = 4'd9,
      FAULT   = 4'd10
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        en_aux_q, en_aux_d;
   logic        en_m12_q, en_m12_d;
   logic        en_m33_q, en_m33_d;
   logic        pwr_ok_q, pwr_ok_d;
   logic        fault_q, fault_d;
   logic [2:0]  code_q, code_d;

   logic pg_exp, step_exp;
   assign pg_exp   = (cnt_q == PG_TIMEOUT);
   assign step_exp = (cnt_q == STEP_DLY);

   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      case (state_q)
         IDLE:    if (bus.pwr_req && !fault_q) state_d = W_AUX;
         // power-good is checked ahead of the timeout, and both ahead of
         // a dropped request, so a late-but-valid pg still advances
         W_AUX: begin
            if (bus.pg_aux)        state_d = D_AUX;
            else if (pg_exp)       begin state_d = FAULT; code_d = 3'd1; end
            else if (!bus.pwr_req) state_d = OFF_AUX;
         end
         D_AUX: begin
            if (step_exp)          state_d = W_M12;
            else if (!bus.pwr_req) state_d = OFF_AUX;
         end
         W_M12: begin
            if (bus.pg_m12)        state_d = D_M12;
            else if (pg_exp)       begin state_d = FAULT; code_d = 3'd2; end
            else if (!bus.pwr_req) state_d = OFF_M12;
         end
         D_M12: begin
            if (step_exp)          state_d = W_M33;
            else if (!bus.pwr_req) state_d = OFF_M12;
         end
         W_M33: begin
            if (bus.pg_m33)        state_d = ON;
            else if (pg_exp)       begin state_d = FAULT; code_d = 3'd3; end
            else if (!bus.pwr_req) state_d = OFF_M33;
         end
         ON: begin
            if (!(bus.pg_aux && bus.pg_m12 && bus.pg_m33)) begin
               state_d = FAULT;
               code_d  = 3'd4;
            end else if (!bus.pwr_req) state_d = OFF_M33;
         end
         // power-down always runs to completion, request is ignored
         OFF_M33: if (step_exp) state_d = OFF_M12;
         OFF_M12: if (step_exp) state_d = OFF_AUX;
         OFF_AUX: if (step_exp) state_d = IDLE;
         FAULT: begin
            if (bus.fault_clr && !bus.pwr_req) begin
               state_d = IDLE;
               code_d  = 3'd0;
            end
         end
         default: begin
            state_d = IDLE;
            code_d  = 3'd0;
         end
      endcase

      // counter restarts on every state change and saturates
      if (state_d != state_q)    cnt_d = 16'd0;
      else if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
      else                        cnt_d = cnt_q;

      // outputs are decoded from the next state so they change on the
      // same edge that enters the state
      en_aux_d = (state_d inside {W_AUX, D_AUX, W_M12, D_M12, W_M33, ON,
                                  OFF_M33, OFF_M12});
      en_m12_d = (state_d inside {W_M12, D_M12, W_M33, ON, OFF_M33});
      en_m33_d = (state_d inside {W_M33, ON});
      pwr_ok_d = (state_d == ON);
      fault_d  = (state_d == FAULT);
   end

   always_ff @(posedge clk_in or posedge iRst) begin
      if (iRst) begin
         state_q  <= IDLE;
         cnt_q    <= 16'd0;
         en_aux_q <= 1'b0;
         en_m12_q <= 1'b0;
         en_m33_q <= 1'b0;
         pwr_ok_q <= 1'b0;
         fault_q  <= 1'b0;
         code_q   <= 3'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         en_aux_q <= en_aux_d;
         en_m12_q <= en_m12_d;
         en_m33_q <= en_m33_d;
         pwr_ok_q <= pwr_ok_d;
         fault_q  <= fault_d;
         code_q   <= code_d;
      end
   end

   assign bus.en_aux     = en_aux_q;
   assign bus.en_m12     = en_m12_q;
   assign bus.en_m33     = en_m33_q;
   assign bus.pwr_ok     = pwr_ok_q;
   assign bus.fault      = fault_q;
   assign bus.fault_code = code_q;
   assign bus.seq_state  = state_q;

endmodule

// File: tb/tb_nic3_pwr_seq.sv
// tb_nic3_pwr_seq
// Directed bench for nic3_pwr_seq with STEP_DLY=4, PG_TIMEOUT=10.
// Table vectors: apply inputs, advance n clock edges, compare the packed
// observation {state, en_aux, en_m12, en_m33, pwr_ok, fault, fault_code}.
// Hand-written sequences cover the pg/timeout tie, an abort in D_M12 and
// asynchronous reset.
module tb_nic3_pwr_seq;

   logic clk_in = 1'b0;
   logic iRst   = 1'b1;
   always #5 clk_in = ~clk_in;

   nic3_pwr_seq_if bus();

   nic3_pwr_seq #(.STEP_DLY(16'd4), .PG_TIMEOUT(16'd10)) dut (
      .clk_in (clk_in),
      .iRst   (iRst),
      .bus    (bus)
   );

   typedef struct {
      logic       req, clr, pa, p12, p33;
      int         n;
      logic [3:0] st;
      logic       ea, e12, e33, ok, flt;
      logic [2:0] code;
   } vec_t;

   vec_t tbl[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic add(input logic req, clr, pa, p12, p33, input int n,
                      input logic [3:0] st, input logic ea, e12, e33, ok, flt,
                      input logic [2:0] code);
      vec_t v;
      v.req = req; v.clr = clr; v.pa = pa; v.p12 = p12; v.p33 = p33; v.n = n;
      v.st = st; v.ea = ea; v.e12 = e12; v.e33 = e33; v.ok = ok; v.flt = flt;
      v.code = code;
      tbl.push_back(v);
   endtask

   function automatic logic [11:0] obs();
      return {bus.seq_state, bus.en_aux, bus.en_m12, bus.en_m33, bus.pwr_ok,
              bus.fault, bus.fault_code};
   endfunction

   function automatic logic [11:0] ex(input logic [3:0] st, input logic ea,
                                      e12, e33, ok, flt, input logic [2:0] code);
      return {st, ea, e12, e33, ok, flt, code};
   endfunction

   task automatic chk(input string nm, input logic [11:0] got, exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   task automatic setin(input logic req, clr, pa, p12, p33);
      bus.pwr_req = req; bus.fault_clr = clr;
      bus.pg_aux = pa; bus.pg_m12 = p12; bus.pg_m33 = p33;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   logic m33_seen;

   initial begin
      //  req clr pa p12 p33  n  st  ea e12 e33 ok flt code
      // power-up, pg 2 cycles after each enable
      add(1,0,0,0,0, 1, 1, 1,0,0,0,0,0);
      add(1,0,0,0,0, 1, 1, 1,0,0,0,0,0);
      add(1,0,1,0,0, 1, 2, 1,0,0,0,0,0);
      add(1,0,1,0,0, 4, 2, 1,0,0,0,0,0);
      add(1,0,1,0,0, 1, 3, 1,1,0,0,0,0);
      add(1,0,1,0,0, 1, 3, 1,1,0,0,0,0);
      add(1,0,1,1,0, 1, 4, 1,1,0,0,0,0);
      add(1,0,1,1,0, 4, 4, 1,1,0,0,0,0);
      add(1,0,1,1,0, 1, 5, 1,1,1,0,0,0);
      add(1,0,1,1,0, 1, 5, 1,1,1,0,0,0);
      add(1,0,1,1,1, 1, 6, 1,1,1,1,0,0);
      add(1,0,1,1,1, 3, 6, 1,1,1,1,0,0);
      // power-down; request returns mid-way and is ignored until IDLE
      add(0,0,1,1,1, 1, 7, 1,1,0,0,0,0);
      add(0,0,1,1,1, 4, 7, 1,1,0,0,0,0);
      add(0,0,1,1,1, 1, 8, 1,0,0,0,0,0);
      add(1,0,1,1,1, 4, 8, 1,0,0,0,0,0);
      add(1,0,1,1,1, 1, 9, 0,0,0,0,0,0);
      add(1,0,1,1,1, 4, 9, 0,0,0,0,0,0);
      add(1,0,1,1,1, 1, 0, 0,0,0,0,0,0);
      add(1,0,0,0,0, 1, 1, 1,0,0,0,0,0);
      // pg_m12 never arrives -> code 2, 11 edges after en_m12
      add(1,0,1,0,0, 1, 2, 1,0,0,0,0,0);
      add(1,0,1,0,0, 5, 3, 1,1,0,0,0,0);
      add(1,0,1,0,0,10, 3, 1,1,0,0,0,0);
      add(1,0,1,0,0, 1,10, 0,0,0,0,1,2);
      add(1,1,1,0,0, 1,10, 0,0,0,0,1,2);
      add(0,0,1,0,0, 2,10, 0,0,0,0,1,2);
      add(0,1,1,0,0, 1, 0, 0,0,0,0,0,0);
      // pg_aux glitch in ON -> code 4, no restart while faulted
      add(1,0,1,1,1, 1, 1, 1,0,0,0,0,0);
      add(1,0,1,1,1, 1, 2, 1,0,0,0,0,0);
      add(1,0,1,1,1, 5, 3, 1,1,0,0,0,0);
      add(1,0,1,1,1, 1, 4, 1,1,0,0,0,0);
      add(1,0,1,1,1, 5, 5, 1,1,1,0,0,0);
      add(1,0,1,1,1, 1, 6, 1,1,1,1,0,0);
      add(1,0,0,1,1, 1,10, 0,0,0,0,1,4);
      add(1,0,1,1,1, 3,10, 0,0,0,0,1,4);
      add(0,1,1,1,1, 1, 0, 0,0,0,0,0,0);
      // AUX timeout -> code 1
      add(1,0,0,0,0, 1, 1, 1,0,0,0,0,0);
      add(1,0,0,0,0,10, 1, 1,0,0,0,0,0);
      add(1,0,0,0,0, 1,10, 0,0,0,0,1,1);
      add(0,1,0,0,0, 1, 0, 0,0,0,0,0,0);
      // M33 timeout -> code 3
      add(1,0,1,1,0, 1, 1, 1,0,0,0,0,0);
      add(1,0,1,1,0, 1, 2, 1,0,0,0,0,0);
      add(1,0,1,1,0, 5, 3, 1,1,0,0,0,0);
      add(1,0,1,1,0, 1, 4, 1,1,0,0,0,0);
      add(1,0,1,1,0, 5, 5, 1,1,1,0,0,0);
      add(1,0,1,1,0,10, 5, 1,1,1,0,0,0);
      add(1,0,1,1,0, 1,10, 0,0,0,0,1,3);
      add(0,1,1,1,0, 1, 0, 0,0,0,0,0,0);
      add(0,0,1,1,0, 2, 0, 0,0,0,0,0,0);

      // reset state
      setin(0,0,0,0,0);
      step(2);
      chk("reset_hold", obs(), ex(0,0,0,0,0,0,0));
      iRst = 1'b0;
      step(2);
      chk("reset_idle", obs(), ex(0,0,0,0,0,0,0));

      foreach (tbl[i]) begin
         setin(tbl[i].req, tbl[i].clr, tbl[i].pa, tbl[i].p12, tbl[i].p33);
         step(tbl[i].n);
         chk($sformatf("vec%0d", i), obs(),
             ex(tbl[i].st, tbl[i].ea, tbl[i].e12, tbl[i].e33, tbl[i].ok,
                tbl[i].flt, tbl[i].code));
      end

      // pg_m33 arrives exactly as the W_M33 counter reaches the limit
      setin(1,0,1,1,0);
      step(1 + 1 + 5 + 1 + 5 + 10);
      chk("tie_w_m33", obs(), ex(5,1,1,1,0,0,0));
      setin(1,0,1,1,1);
      step(1);
      chk("tie_pg_wins", obs(), ex(6,1,1,1,1,0,0));
      setin(0,0,1,1,1);
      step(1 + 5 + 5 + 5);
      chk("tie_down_idle", obs(), ex(0,0,0,0,0,0,0));

      // abort in D_M12: en_m33 must never assert
      m33_seen = 1'b0;
      setin(1,0,1,1,1);
      for (int k = 0; k < 1 + 1 + 5 + 1 + 2; k++) begin
         step(1);
         m33_seen |= bus.en_m33;
      end
      chk("abort_in_d_m12", obs(), ex(4,1,1,0,0,0,0));
      setin(0,0,1,1,1);
      step(1);
      m33_seen |= bus.en_m33;
      chk("abort_off_m12", obs(), ex(8,1,0,0,0,0,0));
      for (int k = 0; k < 10; k++) begin
         step(1);
         m33_seen |= bus.en_m33;
      end
      chk("abort_idle", obs(), ex(0,0,0,0,0,0,0));
      chk("abort_no_m33", {11'd0, m33_seen}, 12'd0);

      // asynchronous reset from ON
      setin(1,0,1,1,1);
      step(14);
      chk("pre_rst_on", obs(), ex(6,1,1,1,1,0,0));
      #2 iRst = 1'b1;
      #1;
      chk("async_rst", obs(), ex(0,0,0,0,0,0,0));
      setin(0,0,1,1,1);
      step(2);
      iRst = 1'b0;
      step(2);
      chk("post_rst_idle", obs(), ex(0,0,0,0,0,0,0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
